// File: rtl/fifo_width_packer_if.sv
// Handshake bundle between a narrow FWFT upstream FIFO read port and a wide
// downstream FIFO write port, as seen by the width packer.
interface fifo_width_packer_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

  logic                 in_empty_n;
  logic                 in_read;
  logic                 in_read_ce;
  logic [IN_WIDTH-1:0]  in_dout;
  logic                 out_full_n;
  logic                 out_write;
  logic                 out_write_ce;
  logic [OUT_WIDTH-1:0] out_din;

  // master: the packer itself; slave: the FIFOs around it
  modport master (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, in_read_ce, out_write, out_write_ce, out_din
  );
  modport slave (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, in_read_ce, out_write, out_write_ce, out_din
  );
endinterface

// File: rtl/fifo_width_packer.sv
// Streaming upsizer: packs RATIO narrow FWFT words (first arrival in the LSBs)
// into one wide word; flush emits a zero-padded partial word.
module fifo_width_packer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_width_packer_if.master  bus,
  input  logic                 flush,
  output logic                 busy
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_WIDTH = $clog2(RATIO);
  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 flush_pending;

  logic slot_free;
  logic out_fire;
  logic rd;
  logic completes;
  logic flush_emit;

  always_comb begin
    slot_free  = !out_valid || bus.out_full_n;
    out_fire   = out_valid && bus.out_full_n;
    // Only the last lane needs the output slot, so backpressure stalls it alone
    rd         = reset && bus.in_empty_n && !flush && !flush_pending &&
                 ((cnt != LAST_LANE) || slot_free);
    completes  = rd && (cnt == LAST_LANE);
    flush_emit = flush_pending && slot_free;
  end

  assign bus.in_read      = rd;
  assign bus.in_read_ce   = 1'b1;
  assign bus.out_write    = out_valid;
  assign bus.out_write_ce = 1'b1;
  assign bus.out_din      = out_data;
  assign busy             = (cnt != '0) || out_valid || flush_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc           <= '0;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (rd) begin
        if (completes) begin
          out_data <= {bus.in_dout, acc[OUT_WIDTH-IN_WIDTH-1:0]};
          acc      <= '0;
          cnt      <= '0;
        end else begin
          for (int i = 0; i < RATIO; i++) begin
            if (cnt == CNT_WIDTH'(i)) acc[i*IN_WIDTH +: IN_WIDTH] <= bus.in_dout;
          end
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end else if (flush_emit) begin
        // Unfilled lanes of acc are already zero, giving the padding for free
        out_data <= acc;
        acc      <= '0;
        cnt      <= '0;
      end

      if (flush_emit)
        flush_pending <= 1'b0;
      else if (flush && (cnt != '0))
        flush_pending <= 1'b1;

      if (completes || flush_emit)
        out_valid <= 1'b1;
      else if (out_fire)
        out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_width_packer.sv
// Bench for fifo_width_packer: directed vector table, hand sequences for
// backpressure/reset, and randomized traffic against a queue-based model.
module tb_fifo_width_packer;
  localparam int IW = 32;
  localparam int R  = 4;
  localparam int OW = IW * R;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  fifo_width_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();

  fifo_width_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .flush(flush),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          rd_s, wr_s, busy_s;
  logic [OW-1:0] dout_s;

  // Model: narrow words accepted so far in the current group, and wide words owed
  logic [IW-1:0] part[$];
  logic [OW-1:0] expq[$];

  typedef struct {
    logic          en, fn, fl;
    logic [IW-1:0] d;
    logic          rd, wr;
    logic [OW-1:0] dout;
    logic          bsy;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_part();
    logic [OW-1:0] w = '0;
    foreach (part[i]) w[i*IW +: IW] = part[i];
    return w;
  endfunction

  // Drive one cycle's inputs at the falling edge, sample just after, update model
  task automatic cycle(input logic en, input logic fn, input logic fl, input logic [IW-1:0] d);
    @(negedge clk);
    bus.in_empty_n = en;
    bus.out_full_n = fn;
    flush          = fl;
    bus.in_dout    = d;
    #1;
    rd_s   = bus.in_read;
    wr_s   = bus.out_write;
    dout_s = bus.out_din;
    busy_s = busy;
    if (rd_s && en) begin
      part.push_back(d);
      if (part.size() == R) begin
        expq.push_back(pack_part());
        part.delete();
      end
    end
    if (fl && part.size() != 0) begin
      expq.push_back(pack_part());
      part.delete();
    end
    if (wr_s && fn) begin
      if (expq.size() == 0) check("unexpected_word", dout_s, '0 ^ {OW{1'b1}} ^ dout_s ^ dout_s);
      else check("word_order", dout_s, expq.pop_front());
    end
  endtask

  logic [IW-1:0] src;
  int            nwr;

  initial begin
    bus.in_empty_n = 1'b1;
    bus.out_full_n = 1'b1;
    bus.in_dout    = 32'h5a5a5a5a;
    #3;
    check("reset_in_read",   {127'b0, bus.in_read},   '0);
    check("reset_out_write", {127'b0, bus.out_write}, '0);
    check("reset_busy",      {127'b0, busy},          '0);
    check("reset_out_din",   bus.out_din,             '0);
    bus.in_empty_n = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // en fn fl d | rd wr dout bsy
    tbl[0]  = '{1, 1, 0, 32'h11, 1, 0, 128'h0, 0};
    tbl[1]  = '{1, 1, 0, 32'h22, 1, 0, 128'h0, 1};
    tbl[2]  = '{1, 1, 0, 32'h33, 1, 0, 128'h0, 1};
    tbl[3]  = '{1, 1, 0, 32'h44, 1, 0, 128'h0, 1};
    tbl[4]  = '{0, 1, 0, 32'h0,  0, 1, 128'h00000044_00000033_00000022_00000011, 1};
    tbl[5]  = '{0, 1, 0, 32'h0,  0, 0, 128'h00000044_00000033_00000022_00000011, 0};
    tbl[6]  = '{1, 1, 0, 32'hA,  1, 0, 128'h00000044_00000033_00000022_00000011, 0};
    tbl[7]  = '{1, 1, 0, 32'hB,  1, 0, 128'h00000044_00000033_00000022_00000011, 1};
    tbl[8]  = '{1, 1, 1, 32'hC,  0, 0, 128'h00000044_00000033_00000022_00000011, 1};
    tbl[9]  = '{1, 1, 0, 32'hC,  0, 0, 128'h00000044_00000033_00000022_00000011, 1};
    tbl[10] = '{0, 1, 0, 32'h0,  0, 1, 128'h0000000B_0000000A, 1};
    tbl[11] = '{0, 1, 0, 32'h0,  0, 0, 128'h0000000B_0000000A, 0};
    tbl[12] = '{0, 1, 1, 32'h0,  0, 0, 128'h0000000B_0000000A, 0};
    tbl[13] = '{0, 1, 0, 32'h0,  0, 0, 128'h0000000B_0000000A, 0};

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].fn, tbl[i].fl, tbl[i].d);
      check($sformatf("vec%0d_in_read", i),   {127'b0, rd_s},   {127'b0, tbl[i].rd});
      check($sformatf("vec%0d_out_write", i), {127'b0, wr_s},   {127'b0, tbl[i].wr});
      check($sformatf("vec%0d_out_din", i),   dout_s,           tbl[i].dout);
      check($sformatf("vec%0d_busy", i),      {127'b0, busy_s}, {127'b0, tbl[i].bsy});
    end

    // Backpressure: hold a word, fill three lanes, last lane must stall
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, IW'(i));
    for (int i = 5; i <= 7; i++) begin
      cycle(1, 0, 0, IW'(i));
      check("bp_lane_read", {127'b0, rd_s}, {127'b0, 1'b1});
    end
    cycle(1, 0, 0, 32'd8);
    check("bp_last_lane_stall", {127'b0, rd_s}, '0);
    check("bp_held_stable", dout_s, 128'h00000004_00000003_00000002_00000001);
    cycle(1, 1, 0, 32'd8);
    check("bp_release_read", {127'b0, rd_s}, {127'b0, 1'b1});
    check("bp_release_write", {127'b0, wr_s}, {127'b0, 1'b1});
    cycle(0, 1, 0, 32'd0);
    check("bp_no_bubble_write", {127'b0, wr_s}, {127'b0, 1'b1});
    check("bp_no_bubble_data", dout_s, 128'h00000008_00000007_00000006_00000005);
    cycle(0, 1, 0, 32'd0);

    // Continuous 16-word stream
    nwr = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, 1, 0, IW'(100 + i));
      check("stream_read", {127'b0, rd_s}, {127'b0, 1'b1});
      if (wr_s) nwr++;
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 32'd0);
      if (wr_s) nwr++;
    end
    check("stream_word_count", OW'(nwr), OW'(4));

    // Asynchronous reset between edges with a held word and two partial lanes
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, IW'(200 + i));
    cycle(1, 0, 0, 32'd210);
    cycle(1, 0, 0, 32'd211);
    @(negedge clk);
    bus.in_empty_n = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_rst_out_write", {127'b0, bus.out_write}, '0);
    check("async_rst_busy",      {127'b0, busy},          '0);
    check("async_rst_in_read",   {127'b0, bus.in_read},   '0);
    part.delete();
    expq.delete();
    bus.in_empty_n = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, IW'(300 + i));
    cycle(0, 1, 0, 32'd0);
    check("post_rst_clean_word", dout_s, {32'd303, 32'd302, 32'd301, 32'd300});

    // Upstream toggling every cycle
    src = 32'h1000;
    for (int i = 0; i < 32; i++) begin
      cycle((i % 2) == 0, 1, 0, src);
      if (rd_s) src++;
    end

    // Random traffic with occasional flushes
    src = $urandom;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, src);
      if (rd_s) src = $urandom;
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'd0);
    cycle(0, 1, 1, 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 32'd0);
    check("drain_all_words", OW'(expq.size()), '0);
    check("drain_idle_busy", {127'b0, busy_s}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_width_packer.md
Name: fifo_width_packer

Overview:
- Streaming upsizer between two TAPA-style FIFOs. It pops RATIO narrow words from an upstream FIFO read port (FWFT semantics, data valid whenever empty_n is high) and pushes one wide word into a downstream FIFO write port.
- Sits directly downstream of a depth-1 forwarding FIFO on narrow-stream channels, e.g. packing quantized activations into memory-width words.
- A flush input drains a partially filled word, zero-padded, at end of stream.

Parameters:
- IN_WIDTH, 32, width of each upstream word.
- RATIO, 4, narrow words per output word; must be >= 2.
- OUT_WIDTH, IN_WIDTH*RATIO, derived localparam, width of each output word; not overridable.
- CNT_WIDTH, $clog2(RATIO), derived localparam, lane-counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Name kept as in codebase; polarity and synchronicity are fixed.
- in_empty_n  in  1  upstream FIFO has valid data on in_dout.
- in_read  out  1  pop upstream word this cycle.
- in_read_ce  out  1  read clock-enable; tied 1.
- in_dout  in  IN_WIDTH  upstream data, FWFT.
- out_full_n  in  1  downstream FIFO can accept a word.
- out_write  out  1  push output word this cycle.
- out_write_ce  out  1  write clock-enable; tied 1.
- out_din  out  OUT_WIDTH  packed output word.
- flush  in  1  single-cycle pulse requesting emission of a partial word.
- busy  out  1  cnt!=0 | out_valid | flush_pending.

Behaviour:
- State registers: acc[OUT_WIDTH], cnt[CNT_WIDTH], out_valid, out_data[OUT_WIDTH], flush_pending.
- Reset (reset==0, async):
  - acc=0, cnt=0, out_valid=0, out_data=0, flush_pending=0.
  - Resulting outputs: out_write=0, out_din=0, busy=0, in_read=0. in_read is gated low combinationally while reset is asserted.
  - Reset mid-word discards all partial and pending data.
- Output side:
  - out_write=out_valid; out_din=out_data.
  - out_fire = out_valid & out_full_n.
  - out_valid clears on out_fire unless it is reloaded in the same cycle.
- Output slot availability: slot_free = !out_valid | out_full_n. A held word plus a new completion in the same cycle is allowed only when out_fire.
- Read enable:
  - in_read = in_empty_n & !flush & !flush_pending & (cnt!=RATIO-1 | slot_free).
  - Narrow words are accepted at 1/cycle whenever the lane is not the last one.
  - Backpressure stalls only the final lane.
- On a read:
  - Lane cnt of acc <= in_dout. Lane 0 = bits [IN_WIDTH-1:0], i.e. first-arrived word at the LSBs.
  - If cnt==RATIO-1: out_data <= {in_dout, acc lanes 0..RATIO-2}, out_valid<=1, cnt<=0, acc<=0.
  - Otherwise cnt<=cnt+1.
- Latency: the final narrow word is read at cycle t; out_write is high at t+1 (registered). Sustained throughput is one output word per RATIO cycles.
- Flush:
  - flush=1 forces in_read=0 that cycle.
  - If cnt!=0: flush_pending<=1. If cnt==0: flush is a no-op; a full word already in out_valid is unaffected.
  - While flush_pending and slot_free: out_data<=acc (unfilled lanes already zero), out_valid<=1, cnt<=0, acc<=0, flush_pending<=0. Reading resumes the next cycle.
  - Flush asserted while flush_pending is ignored.
- Counter wraps RATIO-1 -> 0 only via completion or flush; no other wrap.
- in_empty_n low: no state change on the input side. out_full_n low: out_valid and out_data are held stable; data is never dropped.

Test Plan:
- Reset, then RATIO=4, IN_WIDTH=32, inputs 0x11,0x22,0x33,0x44 back-to-back with out_full_n=1 -> one out_write, out_din=0x00000044_00000033_00000022_00000011, one cycle after the 4th read.
- Continuous 16-word stream with out_full_n=1 -> 4 output words, in_read high every cycle, out_write every 4th cycle, order preserved.
- out_full_n=0 while a word is held and 3 more lanes arrive -> in_read drops on lane 3, out_din stable. out_full_n=1 -> old word pops and new word loads the same cycle with no bubble.
- Inputs 0xA,0xB then flush pulse -> in_read=0 during flush, out_din=0x0_0_B_A (upper two lanes zero), busy falls after the pop. Flush with cnt==0 -> no output.
- Assert reset asynchronously mid-edge after 2 of 4 words -> out_write, busy and in_read are 0 immediately. Next 4 inputs form a clean word with no stale lanes.
- Upstream in_empty_n toggling 1/0 every cycle -> output words are identical to the gap-free case and only delayed.
